// File: rtl/uart_reg_bank.sv
// uart_reg_bank
//   Checksummed register bank fed by the UART byte stream. Incoming 5-byte
//   frames {addr, sub, data_hi, data_lo, chk} write DAC code registers, ADC
//   clock-divider registers or the control bit. A read-request frame (addr F3)
//   snapshots one register and sends a 5-byte response back through the UART
//   transmitter.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   rx_data   received byte, qualified by rx_valid (1-cycle strobe)
//   tx_data   byte to the UART transmitter, qualified by tx_en (1-cycle strobe)
//   tx_busy   UART transmitter busy
//   dac_data  flattened DAC code registers, channel k at [k*DAC_W +: DAC_W]
//   adc_freq  flattened ADC divider registers, channel k at [k*FREQ_W +: FREQ_W]
//   adc_en_u  user ADC/stream enable (control bit 0)
//   reg_wr    1-cycle pulse in the cycle after each applied write
//   err_cnt   saturating count of dropped frames and timeouts
module uart_reg_bank #(
  parameter int          N_DAC       = 8,
  parameter int          DAC_W       = 12,
  parameter int          N_ADC       = 2,
  parameter int          FREQ_W      = 16,
  parameter logic [15:0] FREQ_RST    = 16'd1,
  parameter int          TIMEOUT_CYC = 25000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_en,
  input  logic                    tx_busy,
  output logic [N_DAC*DAC_W-1:0]  dac_data,
  output logic [N_ADC*FREQ_W-1:0] adc_freq,
  output logic                    adc_en_u,
  output logic                    reg_wr,
  output logic [7:0]              err_cnt
);

  localparam logic [7:0] ADDR_DAC  = 8'hFF;
  localparam logic [7:0] ADDR_ADC  = 8'hFE;
  localparam logic [7:0] ADDR_CTRL = 8'h00;
  localparam logic [7:0] ADDR_READ = 8'hF3;
  localparam int         IDLE_W    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {R_ADDR, R_SUB, R_HI, R_LO, R_CHK} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP, T_WAIT} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic [7:0]        addr_reg, sub_reg, hi_reg, lo_reg;
  logic [IDLE_W-1:0] idle_cnt;
  logic [DAC_W-1:0]  dac_reg [N_DAC];
  logic [FREQ_W-1:0] adc_reg [N_ADC];
  logic [7:0]        resp_reg [5];
  logic [2:0]        tx_idx;

  logic        rx_commit, rx_timeout;
  logic [15:0] data16, rd_val;
  logic        chk_ok, dac_hit, adc_hit, ctrl_hit, rd_hit, tgt_ok, rd_ok, wr_ok;
  logic        frame_good, dac_we, adc_we, ctrl_we, rd_start, err_inc;
  logic        tx_fire, tx_adv;

  // ---------------------------------------------------------------- RX FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= R_ADDR;
    else     rx_state <= rx_next;
  end

  // A byte always advances the parser, even in the cycle the idle counter
  // reaches its limit; the timeout only fires on an idle cycle.
  always_comb begin
    rx_next    = rx_state;
    rx_commit  = 1'b0;
    rx_timeout = 1'b0;
    if (rx_valid) begin
      case (rx_state)
        R_ADDR:  rx_next = R_SUB;
        R_SUB:   rx_next = R_HI;
        R_HI:    rx_next = R_LO;
        R_LO:    rx_next = R_CHK;
        R_CHK: begin
          rx_next   = R_ADDR;
          rx_commit = 1'b1;
        end
        default: rx_next = R_ADDR;
      endcase
    end else if (rx_state != R_ADDR && idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
      rx_next    = R_ADDR;
      rx_timeout = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= '0;
      sub_reg  <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
    end else if (rx_valid) begin
      case (rx_state)
        R_ADDR:  addr_reg <= rx_data;
        R_SUB:   sub_reg  <= rx_data;
        R_HI:    hi_reg   <= rx_data;
        R_LO:    lo_reg   <= rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           idle_cnt <= '0;
    else if (rx_state == R_ADDR || rx_valid || rx_timeout) idle_cnt <= '0;
    else                                               idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  // ------------------------------------------------------- frame decode
  // The checksum byte is still on rx_data when the frame commits.
  always_comb begin
    data16   = {hi_reg, lo_reg};
    chk_ok   = ((addr_reg ^ sub_reg ^ hi_reg ^ lo_reg) == rx_data);
    dac_hit  = (addr_reg == ADDR_DAC) && ({24'd0, sub_reg} < 32'(N_DAC));
    adc_hit  = (addr_reg == ADDR_ADC) && ({24'd0, sub_reg} < 32'(N_ADC));
    ctrl_hit = (addr_reg == ADDR_CTRL);
    rd_hit   = (addr_reg == ADDR_READ);
    // For a read, sub carries the target address and data_lo the target sub.
    tgt_ok   = ((sub_reg == ADDR_DAC) && ({24'd0, lo_reg} < 32'(N_DAC))) ||
               ((sub_reg == ADDR_ADC) && ({24'd0, lo_reg} < 32'(N_ADC))) ||
               (sub_reg == ADDR_CTRL);
    // A new read is refused while a previous response is still going out.
    rd_ok    = rd_hit && tgt_ok && (tx_state == T_IDLE);
    wr_ok    = dac_hit || adc_hit || ctrl_hit;

    frame_good = rx_commit && chk_ok && (wr_ok || rd_ok);
    dac_we     = frame_good && dac_hit;
    adc_we     = frame_good && adc_hit;
    ctrl_we    = frame_good && ctrl_hit;
    rd_start   = frame_good && rd_hit;
    err_inc    = rx_timeout || (rx_commit && !frame_good);
  end

  // ---------------------------------------------------------- registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_DAC; k++) dac_reg[k] <= '0;
    end else if (dac_we) begin
      for (int k = 0; k < N_DAC; k++)
        if (sub_reg == 8'(k)) dac_reg[k] <= data16[DAC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_ADC; k++) adc_reg[k] <= FREQ_RST[FREQ_W-1:0];
    end else if (adc_we) begin
      for (int k = 0; k < N_ADC; k++)
        if (sub_reg == 8'(k)) adc_reg[k] <= data16[FREQ_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adc_en_u <= 1'b0;
      reg_wr   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (ctrl_we) adc_en_u <= lo_reg[0];
      reg_wr <= dac_we || adc_we || ctrl_we;
      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  for (genvar gi = 0; gi < N_DAC; gi++) begin : g_dac_out
    assign dac_data[gi*DAC_W +: DAC_W] = dac_reg[gi];
  end
  for (genvar gi = 0; gi < N_ADC; gi++) begin : g_adc_out
    assign adc_freq[gi*FREQ_W +: FREQ_W] = adc_reg[gi];
  end

  // --------------------------------------------------------- readback
  // Value of the read target, zero-extended to 16 bits.
  always_comb begin
    rd_val = '0;
    if (sub_reg == ADDR_DAC) begin
      for (int k = 0; k < N_DAC; k++)
        if (lo_reg == 8'(k)) rd_val = 16'(dac_reg[k]);
    end else if (sub_reg == ADDR_ADC) begin
      for (int k = 0; k < N_ADC; k++)
        if (lo_reg == 8'(k)) rd_val = 16'(adc_reg[k]);
    end else if (sub_reg == ADDR_CTRL) begin
      rd_val = {15'd0, adc_en_u};
    end
  end

  // The whole response is frozen at commit, so later writes to the same
  // register cannot leak into a response already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 5; k++) resp_reg[k] <= '0;
    end else if (rd_start) begin
      resp_reg[0] <= sub_reg;
      resp_reg[1] <= lo_reg;
      resp_reg[2] <= rd_val[15:8];
      resp_reg[3] <= rd_val[7:0];
      resp_reg[4] <= sub_reg ^ lo_reg ^ rd_val[15:8] ^ rd_val[7:0];
    end
  end

  // ---------------------------------------------------------------- TX FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= T_IDLE;
    else     tx_state <= tx_next;
  end

  // T_GAP exists because the transmitter raises tx_busy a cycle after it
  // sees tx_en; checking busy right away would skip the byte in progress.
  always_comb begin
    tx_next = tx_state;
    tx_fire = 1'b0;
    tx_adv  = 1'b0;
    case (tx_state)
      T_IDLE: if (rd_start) tx_next = T_SEND;
      T_SEND: if (!tx_busy) begin
        tx_fire = 1'b1;
        tx_next = T_GAP;
      end
      T_GAP:  tx_next = T_WAIT;
      T_WAIT: if (!tx_busy) begin
        if (tx_idx == 3'd4) begin
          tx_next = T_IDLE;
        end else begin
          tx_adv  = 1'b1;
          tx_next = T_SEND;
        end
      end
      default: tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en   <= 1'b0;
      tx_data <= '0;
      tx_idx  <= '0;
    end else begin
      tx_en <= tx_fire;
      if (tx_fire)       tx_data <= resp_reg[tx_idx];
      if (rd_start)      tx_idx  <= '0;
      else if (tx_adv)   tx_idx  <= tx_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_uart_reg_bank.sv
// Testbench for uart_reg_bank: table of write frames with expected register
// state, followed by hand-written readback, timeout and reset sequences.
module tb_uart_reg_bank;
  localparam int T = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic [95:0] dac_data;
  logic [31:0] adc_freq;
  logic        adc_en_u;
  logic        reg_wr;
  logic [7:0]  err_cnt;

  uart_reg_bank #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .dac_data(dac_data), .adc_freq(adc_freq), .adc_en_u(adc_en_u),
    .reg_wr(reg_wr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // UART transmitter model: busy rises one cycle after tx_en, held 8 cycles.
  int bcnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst)             bcnt <= 0;
    else if (tx_en)      bcnt <= 8;
    else if (bcnt != 0)  bcnt <= bcnt - 1;
  end
  assign tx_busy = (bcnt != 0);

  // Transmit monitor: collect bytes, check each strobe is single-cycle and
  // was issued while the transmitter was idle.
  logic [7:0] txq[$];
  logic prev_busy = 1'b0;
  logic prev_en   = 1'b0;
  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      chk("tx_en_busy_low", 96'(prev_busy), 96'd0);
      chk("tx_en_one_cycle", 96'(prev_en), 96'd0);
      txq.push_back(tx_data);
    end
    prev_busy = tx_busy;
    prev_en   = tx_en;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) send_byte(f[39-8*i -: 8]);
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 1000 && txq.size() < n; i++) @(posedge clk);
    #1;
    chk("tx_count", 96'(txq.size()), 96'(n));
  endtask

  task automatic check_resp(input string nm, input logic [39:0] e);
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_byte%0d", nm, i), 96'(txq[i]), 96'(e[39-8*i -: 8]));
  endtask

  typedef struct packed {
    logic [39:0] frame;
    logic [95:0] dac;
    logic [31:0] freq;
    logic        en;
    logic [7:0]  err;
    logic        wr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [95:0] d0, d1;
    d0 = 96'hABC << 36;
    d1 = d0 | (96'hFFF << 84);
    vecs[0] = '{40'hFF030ABC4A, d0,  32'h00010001, 1'b0, 8'd0, 1'b1};
    vecs[1] = '{40'hFF030ABC00, d0,  32'h00010001, 1'b0, 8'd1, 1'b0};
    vecs[2] = '{40'hFE011234D9, d0,  32'h12340001, 1'b0, 8'd1, 1'b1};
    vecs[3] = '{40'h0000000101, d0,  32'h12340001, 1'b1, 8'd1, 1'b1};
    vecs[4] = '{40'hFF080001F6, d0,  32'h12340001, 1'b1, 8'd2, 1'b0};
    vecs[5] = '{40'hFF07FFFFF8, d1,  32'h12340001, 1'b1, 8'd2, 1'b1};
    vecs[6] = '{40'hFE000000FE, d1,  32'h12340000, 1'b1, 8'd2, 1'b1};
    vecs[7] = '{40'h7700000077, d1,  32'h12340000, 1'b1, 8'd3, 1'b0};
    vecs[8] = '{40'hFE020005F9, d1,  32'h12340000, 1'b1, 8'd4, 1'b0};
    vecs[9] = '{40'h0055AA00FF, d1,  32'h12340000, 1'b0, 8'd4, 1'b1};

    #1 rst = 1'b1;
    idle(3);
    chk("rst_tx_en",   96'(tx_en),    96'd0);
    chk("rst_tx_data", 96'(tx_data),  96'd0);
    chk("rst_dac",     dac_data,      96'd0);
    chk("rst_freq",    96'(adc_freq), 96'h00010001);
    chk("rst_en",      96'(adc_en_u), 96'd0);
    chk("rst_wr",      96'(reg_wr),   96'd0);
    chk("rst_err",     96'(err_cnt),  96'd0);
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < 10; v++) begin
      send_frame(vecs[v].frame);
      chk($sformatf("v%0d_wr", v),   96'(reg_wr),   96'(vecs[v].wr));
      chk($sformatf("v%0d_dac", v),  dac_data,      vecs[v].dac);
      chk($sformatf("v%0d_freq", v), 96'(adc_freq), 96'(vecs[v].freq));
      chk($sformatf("v%0d_en", v),   96'(adc_en_u), 96'(vecs[v].en));
      chk($sformatf("v%0d_err", v),  96'(err_cnt),  96'(vecs[v].err));
      idle(1);
      chk($sformatf("v%0d_wr_drop", v), 96'(reg_wr), 96'd0);
    end

    // Readback of DAC ch3; overwrite it and issue a second read while the
    // first response is still being sent.
    idle(4);
    txq.delete();
    send_frame(40'hF3FF00030F);
    send_frame(40'hFF030123DE);
    send_frame(40'hF3FE00010C);
    wait_tx(5);
    check_resp("rd_dac3", 40'hFF030ABC4A);
    chk("rd_busy_err", 96'(err_cnt), 96'd5);
    chk("wr_during_tx", 96'(dac_data[47:36]), 96'h123);

    idle(20);
    txq.delete();
    send_frame(40'hF3FE00010C);
    wait_tx(5);
    check_resp("rd_adc1", 40'hFE011234D9);
    idle(20);

    // Timeout: partial frame discarded after T idle cycles.
    send_byte(8'hFF);
    send_byte(8'h03);
    idle(T);
    chk("timeout_err", 96'(err_cnt), 96'd6);
    send_frame(40'hFF030ABC4A);
    chk("after_timeout_dac3", 96'(dac_data[47:36]), 96'hABC);
    chk("after_timeout_err", 96'(err_cnt), 96'd6);

    // A byte arriving in the cycle the limit is reached is still accepted.
    send_byte(8'hFF);
    idle(T - 1);
    send_byte(8'h01);
    idle(T - 1);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'hFB);
    chk("edge_timeout_dac1", 96'(dac_data[23:12]), 96'h005);
    chk("edge_timeout_err",  96'(err_cnt), 96'd6);

    // Reset in the middle of a response.
    idle(4);
    txq.delete();
    send_frame(40'hF3FF00010D);
    wait_tx(2);
    for (int i = 0; i < 200 && tx_en !== 1'b1; i++) @(negedge clk);
    chk("mid_tx_strobe_seen", 96'(tx_en), 96'd1);
    rst = 1'b1;
    #1;
    chk("arst_tx_en",   96'(tx_en),    96'd0);
    chk("arst_tx_data", 96'(tx_data),  96'd0);
    chk("arst_dac",     dac_data,      96'd0);
    chk("arst_freq",    96'(adc_freq), 96'h00010001);
    chk("arst_en",      96'(adc_en_u), 96'd0);
    chk("arst_err",     96'(err_cnt),  96'd0);
    idle(2);
    rst = 1'b0;
    txq.delete();
    idle(80);
    chk("no_resume", 96'(txq.size()), 96'd0);
    send_frame(40'hFF030ABC4A);
    chk("post_rst_dac3", 96'(dac_data[47:36]), 96'hABC);
    chk("post_rst_wr",   96'(reg_wr), 96'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
